// File: rtl/mmio_ctrl_ws_if.sv
// mmio_ctrl_ws_if
// Bundles the FPro-side bus signals, the slot-array signals and the error
// reporting signals of the MMIO slot controller.
//   slave  modport : controller view (bus requests and slot replies in,
//                    completion, strobes and status out)
//   master modport : bus + slot-array environment view (the reverse)
// Parameters: N_SLOT slot count, REG_W register-address bits per slot.
interface mmio_ctrl_ws_if #(
  parameter int N_SLOT = 64,
  parameter int REG_W  = 5
);
  // FPro bus side
  logic                         mmio_cs;
  logic                         mmio_wr;
  logic                         mmio_rd;
  logic [20:0]                  mmio_addr;
  logic [31:0]                  mmio_wr_data;
  logic [31:0]                  mmio_rd_data;
  logic                         mmio_ready;
  logic                         busy;
  // slot array side
  logic [N_SLOT-1:0]            slot_cs_array;
  logic [N_SLOT-1:0]            slot_mem_rd_array;
  logic [N_SLOT-1:0]            slot_mem_wr_array;
  logic [N_SLOT-1:0][REG_W-1:0] slot_reg_addr_array;
  logic [N_SLOT-1:0][31:0]      slot_wr_data_array;
  logic [N_SLOT-1:0][31:0]      slot_rd_data_array;
  logic [N_SLOT-1:0]            slot_ready_array;
  // error reporting
  logic                         err_clr;
  logic                         err_flag;
  logic                         overrun_flag;
  logic [20:0]                  err_addr;

  modport slave (
    input  mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
    output mmio_rd_data, mmio_ready, busy,
    output slot_cs_array, slot_mem_rd_array, slot_mem_wr_array,
    output slot_reg_addr_array, slot_wr_data_array,
    input  slot_rd_data_array, slot_ready_array,
    input  err_clr,
    output err_flag, overrun_flag, err_addr
  );

  modport master (
    output mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
    input  mmio_rd_data, mmio_ready, busy,
    input  slot_cs_array, slot_mem_rd_array, slot_mem_wr_array,
    input  slot_reg_addr_array, slot_wr_data_array,
    output slot_rd_data_array, slot_ready_array,
    output err_clr,
    input  err_flag, overrun_flag, err_addr
  );
endinterface

// File: rtl/mmio_ctrl_ws.sv
// mmio_ctrl_ws
// MMIO slot controller with per-slot wait states, bus timeout and error
// capture. Decodes slot/register fields of the word address, issues a
// single-cycle slot strobe, waits for the slot's ready, then returns read
// data with a one-cycle mmio_ready pulse.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : mmio_ctrl_ws_if.slave (bus request/completion, slot strobes,
//           slot replies, sticky error flags and error address)
module mmio_ctrl_ws #(
  parameter int          N_SLOT   = 64,
  parameter int          REG_W    = 5,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic          clk,
  input  logic          reset,
  mmio_ctrl_ws_if.slave bus
);
  localparam int SLOT_W = $clog2(N_SLOT);
  localparam int DEC_W  = REG_W + SLOT_W;
  // A disabled timeout still gets a 1-bit counter so the logic stays legal.
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] idx_q, idx_d;
  logic [REG_W-1:0]  reg_addr_q, reg_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              op_rd_q, op_rd_d;
  logic [20:0]       addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              err_flag_q, err_flag_d;
  logic              ovr_flag_q, ovr_flag_d;
  logic [20:0]       err_addr_q, err_addr_d;

  logic        req;
  logic        miss;
  logic [10:0] above_bits;
  logic        sel_ready;
  logic        err_event;

  assign req       = bus.mmio_cs & (bus.mmio_rd | bus.mmio_wr);
  // Bits above the slot field must be zero; with a full 64-slot array the
  // shift empties the vector and no address can miss.
  assign above_bits = bus.mmio_addr[10:0] >> DEC_W;
  assign miss       = |above_bits;
  assign sel_ready  = bus.slot_ready_array[idx_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      reg_addr_q <= '0;
      wr_data_q  <= '0;
      op_rd_q    <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      err_flag_q <= 1'b0;
      ovr_flag_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      reg_addr_q <= reg_addr_d;
      wr_data_q  <= wr_data_d;
      op_rd_q    <= op_rd_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      err_flag_q <= err_flag_d;
      ovr_flag_q <= ovr_flag_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    reg_addr_d = reg_addr_q;
    wr_data_d  = wr_data_q;
    op_rd_d    = op_rd_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    err_addr_d = err_addr_q;
    err_event  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d      = bus.mmio_addr[REG_W +: SLOT_W];
          reg_addr_d = bus.mmio_addr[REG_W-1:0];
          wr_data_d  = bus.mmio_wr_data;
          op_rd_d    = bus.mmio_rd;      // read wins when both are set
          addr_d     = bus.mmio_addr;
          cnt_d      = '0;
          if (miss) begin
            state_d    = S_DONE;
            err_event  = 1'b1;
            err_addr_d = bus.mmio_addr;
            if (bus.mmio_rd) rd_data_d = ERR_DATA;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (sel_ready) begin
          if (op_rd_q) rd_data_d = bus.slot_rd_data_array[idx_q];
          state_d = S_DONE;
        end else begin
          cnt_d   = CNT_W'(1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A slot answering in the very cycle the limit is reached still
        // completes normally: ready is checked before the timeout.
        if (sel_ready) begin
          if (op_rd_q) rd_data_d = bus.slot_rd_data_array[idx_q];
          state_d = S_DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LIMIT)) begin
          err_event  = 1'b1;
          err_addr_d = addr_q;
          if (op_rd_q) rd_data_d = ERR_DATA;
          state_d = S_DONE;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Sticky flags: a new event in the clearing cycle wins over err_clr.
    err_flag_d = (err_flag_q & ~bus.err_clr) | err_event;
    ovr_flag_d = (ovr_flag_q & ~bus.err_clr) | (req & (state_q != S_IDLE));
  end

  assign bus.mmio_rd_data = rd_data_q;
  assign bus.mmio_ready   = (state_q == S_DONE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.err_flag     = err_flag_q;
  assign bus.overrun_flag = ovr_flag_q;
  assign bus.err_addr     = err_addr_q;

  // Strobes come straight from the state register so an asynchronous reset
  // drops them immediately.
  generate
    for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_slot
      logic hit;
      assign hit = (idx_q == SLOT_W'(gi));
      assign bus.slot_cs_array[gi]       = hit & ((state_q == S_ACCESS) | (state_q == S_WAIT));
      assign bus.slot_mem_rd_array[gi]   = hit & (state_q == S_ACCESS) & op_rd_q;
      assign bus.slot_mem_wr_array[gi]   = hit & (state_q == S_ACCESS) & ~op_rd_q;
      assign bus.slot_reg_addr_array[gi] = reg_addr_q;
      assign bus.slot_wr_data_array[gi]  = wr_data_q;
    end
  endgenerate
endmodule

// File: tb/tb_mmio_ctrl_ws.sv
module tb_mmio_ctrl_ws;
  localparam int N_SLOT  = 16;
  localparam int REG_W   = 5;
  localparam int TIMEOUT = 8;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
  localparam int NVEC = 11;
  localparam int STUCK = 255;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mmio_ctrl_ws_if #(.N_SLOT(N_SLOT), .REG_W(REG_W)) bus_if();

  mmio_ctrl_ws #(
    .N_SLOT(N_SLOT), .REG_W(REG_W), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus_if)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [20:0] addr;
    logic [31:0] wdata;
    logic [31:0] sdata;      // read data presented by the addressed slot
    int          delay;      // cycles after the strobe before ready rises
    int          exp_lat;
    int          exp_rds;
    int          exp_wrs;
    int          exp_cs;
    logic [4:0]  exp_reg;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [20:0] exp_eaddr;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic slots_default();
    for (int i = 0; i < N_SLOT; i++) begin
      bus_if.slot_rd_data_array[i] = 32'hBAD0_0000 | 32'(i);
      bus_if.slot_ready_array[i]   = 1'b1;
    end
  endtask

  task automatic run_vec(input int v);
    vec_t        t;
    int          idx;
    int          lat, rds, wrs, cs_n, rdy_n, others;
    logic [4:0]  reg_seen;
    logic [31:0] wd_seen;
    logic [31:0] prev_rd;
    logic [N_SLOT-1:0] mask;
    bit          hold_ok;
    t = vecs[v];
    idx = int'(t.addr[8:5]);
    lat = 0; rds = 0; wrs = 0; cs_n = 0; rdy_n = 0; others = 0;
    reg_seen = 'x; wd_seen = 'x; hold_ok = 1'b1;
    mask = ~(N_SLOT'(1) << idx);
    prev_rd = bus_if.mmio_rd_data;
    @(negedge clk);
    slots_default();
    bus_if.slot_rd_data_array[idx] = t.sdata;
    bus_if.slot_ready_array[idx]   = 1'b0;
    bus_if.mmio_cs      = 1'b1;
    bus_if.mmio_rd      = t.rd;
    bus_if.mmio_wr      = t.wr;
    bus_if.mmio_addr    = t.addr;
    bus_if.mmio_wr_data = t.wdata;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bus_if.mmio_cs = 1'b0;
        bus_if.mmio_rd = 1'b0;
        bus_if.mmio_wr = 1'b0;
      end
      bus_if.slot_ready_array[idx] = (n > t.delay);
      rds  += int'(bus_if.slot_mem_rd_array[idx]);
      wrs  += int'(bus_if.slot_mem_wr_array[idx]);
      cs_n += int'(bus_if.slot_cs_array[idx]);
      if (|((bus_if.slot_cs_array | bus_if.slot_mem_rd_array | bus_if.slot_mem_wr_array) & mask))
        others++;
      if (bus_if.slot_mem_rd_array[idx] | bus_if.slot_mem_wr_array[idx]) begin
        reg_seen = bus_if.slot_reg_addr_array[idx];
        wd_seen  = bus_if.slot_wr_data_array[idx];
      end
      if (bus_if.mmio_ready) begin
        rdy_n++;
        if (lat == 0) lat = n;
      end else if (lat == 0 && bus_if.mmio_rd_data !== prev_rd) begin
        hold_ok = 1'b0;
      end
      if (lat != 0 && n >= lat + 1) break;
    end
    $display("vec %0d addr %06h rd %0b wr %0b latency %0d rd_data %08h err %0b err_addr %06h",
             v, t.addr, t.rd, t.wr, lat, bus_if.mmio_rd_data, bus_if.err_flag, bus_if.err_addr);
    check($sformatf("v%0d latency", v), 64'(lat), 64'(t.exp_lat));
    check($sformatf("v%0d ready_pulses", v), 64'(rdy_n), 64'd1);
    check($sformatf("v%0d rd_strobes", v), 64'(rds), 64'(t.exp_rds));
    check($sformatf("v%0d wr_strobes", v), 64'(wrs), 64'(t.exp_wrs));
    check($sformatf("v%0d cs_cycles", v), 64'(cs_n), 64'(t.exp_cs));
    check($sformatf("v%0d other_slots", v), 64'(others), 64'd0);
    check($sformatf("v%0d rd_data_hold", v), 64'(hold_ok), 64'd1);
    check($sformatf("v%0d rd_data", v), 64'(bus_if.mmio_rd_data), 64'(t.exp_rdata));
    check($sformatf("v%0d err_flag", v), 64'(bus_if.err_flag), 64'(t.exp_err));
    check($sformatf("v%0d err_addr", v), 64'(bus_if.err_addr), 64'(t.exp_eaddr));
    check($sformatf("v%0d overrun", v), 64'(bus_if.overrun_flag), 64'd0);
    if (t.exp_rds + t.exp_wrs > 0)
      check($sformatf("v%0d reg_addr", v), 64'(reg_seen), 64'(t.exp_reg));
    if (t.exp_wrs > 0)
      check($sformatf("v%0d wr_data", v), 64'(wd_seen), 64'(t.wdata));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},       64'(bus_if.busy), 64'd0);
    check({tag, " mmio_ready"}, 64'(bus_if.mmio_ready), 64'd0);
    check({tag, " rd_data"},    64'(bus_if.mmio_rd_data), 64'd0);
    check({tag, " err_flag"},   64'(bus_if.err_flag), 64'd0);
    check({tag, " overrun"},    64'(bus_if.overrun_flag), 64'd0);
    check({tag, " err_addr"},   64'(bus_if.err_addr), 64'd0);
    check({tag, " strobes"},    64'(bus_if.slot_cs_array | bus_if.slot_mem_rd_array | bus_if.slot_mem_wr_array), 64'd0);
    check({tag, " reg_addr"},   64'(|bus_if.slot_reg_addr_array), 64'd0);
    check({tag, " wr_data"},    64'(|bus_if.slot_wr_data_array), 64'd0);
  endtask

  initial begin
    int seen;
    //            rd    wr    addr        wdata         sdata         delay lat rds wrs cs reg    rdata         err   eaddr
    vecs[0]  = '{1'b1, 1'b0, 21'h000061, 32'h0,        32'h0000_00A5, 0,    2,  1,  0,  1, 5'd1,  32'h0000_00A5, 1'b0, 21'h0};
    vecs[1]  = '{1'b0, 1'b1, 21'h000142, 32'h0000_1234, 32'h1111_1111, 4,   6,  0,  1,  5, 5'd2,  32'h0000_00A5, 1'b0, 21'h0};
    vecs[2]  = '{1'b1, 1'b0, 21'h0001E7, 32'h0,        32'h5A5A_0F0F, 2,    4,  1,  0,  3, 5'd7,  32'h5A5A_0F0F, 1'b0, 21'h0};
    vecs[3]  = '{1'b1, 1'b1, 21'h00001F, 32'hFFFF_0000, 32'h0BAD_F00D, 0,   2,  1,  0,  1, 5'd31, 32'h0BAD_F00D, 1'b0, 21'h0};
    vecs[4]  = '{1'b0, 1'b1, 21'h0000C0, 32'h8765_4321, 32'h0,        8,    10, 0,  1,  9, 5'd0,  32'h0BAD_F00D, 1'b0, 21'h0};
    vecs[5]  = '{1'b1, 1'b0, 21'h000044, 32'h0,        32'h1357_9BDF, 8,    10, 1,  0,  9, 5'd4,  32'h1357_9BDF, 1'b0, 21'h0};
    vecs[6]  = '{1'b1, 1'b0, 21'h0000A0, 32'h0,        32'h7777_7777, STUCK, 10, 1, 0,  9, 5'd0,  32'hDEAD_BEEF, 1'b1, 21'h0000A0};
    vecs[7]  = '{1'b0, 1'b1, 21'h0000E4, 32'h0000_ABCD, 32'h0,        STUCK, 10, 0, 1,  9, 5'd4,  32'hDEAD_BEEF, 1'b1, 21'h0000E4};
    vecs[8]  = '{1'b1, 1'b0, 21'h01F865, 32'h0,        32'h2468_ACE0, 1,    3,  1,  0,  2, 5'd5,  32'h2468_ACE0, 1'b1, 21'h0000E4};
    vecs[9]  = '{1'b1, 1'b0, 21'h000600, 32'h0,        32'h0,        0,     1,  0,  0,  0, 5'd0,  32'hDEAD_BEEF, 1'b1, 21'h000600};
    vecs[10] = '{1'b0, 1'b1, 21'h1007E3, 32'h0000_5555, 32'h0,        0,    1,  0,  0,  0, 5'd0,  32'hDEAD_BEEF, 1'b1, 21'h1007E3};

    bus_if.mmio_cs = 1'b0;
    bus_if.mmio_rd = 1'b0;
    bus_if.mmio_wr = 1'b0;
    bus_if.mmio_addr = '0;
    bus_if.mmio_wr_data = '0;
    bus_if.err_clr = 1'b0;
    slots_default();

    // reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("idle_after_reset");
    $display("reset released, outputs idle");

    for (int v = 0; v < NVEC; v++) run_vec(v);

    // overrun, then overrun coinciding with err_clr
    @(negedge clk);
    slots_default();
    bus_if.slot_rd_data_array[2] = 32'hC0DE_0002;
    bus_if.slot_ready_array[2]   = 1'b0;
    bus_if.mmio_cs = 1'b1; bus_if.mmio_rd = 1'b1; bus_if.mmio_addr = 21'h000044;
    @(negedge clk);                     // ACCESS: a write request arrives while busy
    bus_if.mmio_rd = 1'b0; bus_if.mmio_wr = 1'b1; bus_if.mmio_addr = 21'h000061;
    @(negedge clk);                     // WAIT
    bus_if.mmio_cs = 1'b0; bus_if.mmio_wr = 1'b0;
    check("ovr flag_set", 64'(bus_if.overrun_flag), 64'd1);
    check("ovr cs_only_slot2", 64'(bus_if.slot_cs_array), 64'h0004);
    check("ovr no_strobe", 64'(bus_if.slot_mem_rd_array | bus_if.slot_mem_wr_array), 64'd0);
    $display("overrun while busy: overrun_flag %0b", bus_if.overrun_flag);
    bus_if.mmio_cs = 1'b1; bus_if.mmio_rd = 1'b1; bus_if.err_clr = 1'b1;
    @(negedge clk);
    bus_if.mmio_cs = 1'b0; bus_if.mmio_rd = 1'b0; bus_if.err_clr = 1'b0;
    check("ovr set_beats_clr", 64'(bus_if.overrun_flag), 64'd1);
    check("ovr err_flag_cleared", 64'(bus_if.err_flag), 64'd0);
    $display("overrun with err_clr: overrun_flag %0b err_flag %0b", bus_if.overrun_flag, bus_if.err_flag);
    bus_if.slot_ready_array[2] = 1'b1;
    seen = 0;
    for (int n = 0; n < 20 && seen == 0; n++) begin
      @(negedge clk);
      if (bus_if.mmio_ready) seen = 1;
    end
    check("ovr completion_seen", 64'(seen), 64'd1);
    check("ovr rd_data", 64'(bus_if.mmio_rd_data), 64'hC0DE_0002);
    @(negedge clk);
    bus_if.err_clr = 1'b1;
    @(negedge clk);
    bus_if.err_clr = 1'b0;
    check("clr overrun", 64'(bus_if.overrun_flag), 64'd0);
    check("clr err_flag", 64'(bus_if.err_flag), 64'd0);
    check("clr err_addr_kept", 64'(bus_if.err_addr), 64'h1007E3);
    $display("err_clr: overrun_flag %0b err_flag %0b err_addr %06h",
             bus_if.overrun_flag, bus_if.err_flag, bus_if.err_addr);

    // reset while slot 2 stalls in WAIT
    bus_if.slot_ready_array[2] = 1'b0;
    bus_if.mmio_cs = 1'b1; bus_if.mmio_rd = 1'b1; bus_if.mmio_addr = 21'h000044;
    @(negedge clk);
    bus_if.mmio_cs = 1'b0; bus_if.mmio_rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstwait busy", 64'(bus_if.busy), 64'd1);
    check("rstwait cs_held", 64'(bus_if.slot_cs_array), 64'h0004);
    #2 reset = 1'b0;
    #1 check_all_zero("rst_mid_wait");
    $display("reset asserted mid-WAIT: busy %0b cs %04h", bus_if.busy, bus_if.slot_cs_array);
    @(negedge clk);
    reset = 1'b1;
    bus_if.slot_ready_array[2] = 1'b1;
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (bus_if.mmio_ready | bus_if.busy) seen++;
    end
    check("rst no_completion", 64'(seen), 64'd0);
    $display("after reset release: spurious completions %0d", seen);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmio_ctrl_ws.md
# mmio_ctrl_ws

Parametrised MMIO slot controller with per-slot wait-state handshake, bus timeout and error capture. It sits between the FPro bus and the peripheral slot array inside the MMIO subsystem. It decodes the slot and register fields, issues single-cycle slot strobes, and then waits for the addressed slot's `ready` before returning read data and a completion pulse to the bus. Slot count, register-field width and timeout are generics, so the same block serves small and full 64-slot subsystems.

## Interface
- `N_SLOT`, 64: number of slots; power of 2, range 2..64. `SLOT_W = $clog2(N_SLOT)`.
- `REG_W`, 5: register-address bits per slot.
- `TIMEOUT`, 255: maximum wait cycles before an error completion; 0 disables the timeout.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on an error completion.

Ports (clock and reset first):
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mmio_cs`  in  1  bus select.
- `mmio_wr`  in  1  write request.
- `mmio_rd`  in  1  read request.
- `mmio_addr`  in  21  word address; bits [10:0] are decoded.
- `mmio_wr_data`  in  32  write data.
- `mmio_rd_data`  out  32  read data; registered and held until the next read completion.
- `mmio_ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `slot_cs_array`  out  N_SLOT  one-hot slot select.
- `slot_mem_rd_array`  out  N_SLOT  one-hot read strobe.
- `slot_mem_wr_array`  out  N_SLOT  one-hot write strobe.
- `slot_reg_addr_array`  out  REG_W x N_SLOT  latched register address, broadcast to every slot.
- `slot_wr_data_array`  out  32 x N_SLOT  latched write data, broadcast to every slot.
- `slot_rd_data_array`  in  32 x N_SLOT  per-slot read data.
- `slot_ready_array`  in  N_SLOT  per-slot access-complete flag; slots with no wait states tie this high.
- `err_clr`  in  1  synchronous clear of the sticky error flags.
- `err_flag`  out  1  sticky flag: a timeout or decode miss occurred.
- `overrun_flag`  out  1  sticky flag: a request arrived while `busy`.
- `err_addr`  out  21  address of the most recent errored access.

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE, on `mmio_cs & (mmio_rd | mmio_wr)`:
  - Latch slot index = `mmio_addr[REG_W +: SLOT_W]`.
  - Latch register address = `mmio_addr[REG_W-1:0]`, write data, and the operation. Read has priority if both `mmio_rd` and `mmio_wr` are set.
  - Decode miss: any of `mmio_addr[10:REG_W+SLOT_W]` is nonzero. On a miss, go directly to DONE as an error and issue no slot strobe.
  - Otherwise go to ACCESS.
- ACCESS (exactly one cycle):
  - Assert `slot_cs_array[idx]` and the selected `slot_mem_rd_array[idx]` or `slot_mem_wr_array[idx]`; all other bits stay 0.
  - Sample `slot_ready_array[idx]`. If 1, capture read data and go to DONE; otherwise go to WAIT with the wait counter at 1.
- WAIT:
  - `slot_cs_array[idx]` stays high; the read/write strobes are low.
  - If `slot_ready_array[idx]` is 1, capture `slot_rd_data_array[idx]` (reads only) and go to DONE.
  - Else, if `TIMEOUT != 0` and the counter equals `TIMEOUT`, complete as an error and go to DONE.
  - Otherwise increment the counter. The counter is `$clog2(TIMEOUT+1)` bits and saturates; it never wraps.
- DONE (one cycle): `mmio_ready` = 1; return to IDLE.
- Error completion:
  - A read returns `mmio_rd_data = ERR_DATA`; a write completes with no data change.
  - `err_flag` is set and `err_addr` is loaded with the offending address.
- A successful write leaves `mmio_rd_data` unchanged.
- Any request seen while `busy` is dropped and sets `overrun_flag`. The slot strobes are unaffected.
- `err_clr` clears `err_flag` and `overrun_flag`. If a new error or overrun occurs in the same cycle, the set wins. `err_addr` is not cleared.

## Timing
- Reset (asynchronous, active-low): state goes to IDLE, and every output is 0, including `mmio_rd_data`, `err_addr`, both flags, `busy`, `mmio_ready` and all slot arrays.
- Reset asserted mid-transaction deasserts strobes immediately. The aborted access produces no `mmio_ready`.
- Request sampled at edge E0: ACCESS occupies cycle E0..E1, DONE occupies E1..E2, and `mmio_ready` with valid data is high in that cycle. This is the minimum latency: 2 cycles.
- Each cycle of slot wait adds 1 cycle of latency.
- Timeout completion: `mmio_ready` is high `TIMEOUT + 2` cycles after the request.
- Decode miss: `mmio_ready` is high 1 cycle after the request.
- The next request is accepted in the cycle after DONE; back-to-back throughput is one access per 3 cycles minimum.
- `mmio_rd_data` changes only on the edge that enters DONE for a read.

## Test plan
- Zero-wait read: slot 3 ready tied high, `rd_data` = 32'h0000_00A5, read addr 0x061 → one-cycle `slot_mem_rd_array[3]` pulse, `reg_addr` = 1, `mmio_ready` 2 cycles later, `mmio_rd_data` = 0xA5.
- Wait-state write: slot 10 ready rises 4 cycles after the strobe, write 0x1234 to addr 0x142 → single write strobe with `wr_data` 0x1234, `cs[10]` held high through WAIT, `mmio_ready` 6 cycles after the request, `err_flag` stays 0.
- Timeout: `TIMEOUT` = 8, slot 5 ready stuck low, read addr 0x0A0 → `mmio_ready` at cycle 10, data 0xDEADBEEF, `err_flag` = 1, `err_addr` = 0x0A0.
- Decode miss: `N_SLOT` = 16, read addr 0x600 → no slot strobe, `mmio_ready` at cycle 1, `ERR_DATA` returned, `err_addr` = 0x600.
- Overrun and clear: a second request issued while `busy` → it is ignored and `overrun_flag` = 1. Pulsing `err_clr` clears the flag, except when an overrun lands in the same cycle, in which case the flag stays 1.
- Reset mid-WAIT: drive `reset` low while slot 2 is stalled → all outputs 0 immediately, and no `mmio_ready` appears after reset release.
